fp_addsub_seq: RTL and testbench

- Multi-cycle 9-bit floating-point add/subtract unit on the processor data bus.
- Sits directly downstream of the control FSM and is driven by its AFin, GFin, AddSubF and GFout strobes.
- AFin captures operand A from the bus. GFin captures operand B and starts the operation.
- The result is held in a result register and driven onto the bus when GFout is asserted. busy/done let the FSM wait for variable latency.

---
 rtl/fp_addsub_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle 9-bit floating-point add/subtract unit fed from the data bus.
// Define FP_FLAGS_EN to add the ovf/unf/inexact status outputs.
`timescale 1ns/1ps
module fp_addsub_seq #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 4,
    parameter int BIAS  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   bus_in,
    input  logic                   AFin,
    input  logic                   GFin,
    input  logic                   AddSubF,
    input  logic                   GFout,
    output logic [EXP_W+MAN_W:0]   bus_out,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   busy,
    output logic                   done
`ifdef FP_FLAGS_EN
    ,
    output logic                   ovf,
    output logic                   unf,
    output logic                   inexact
`endif
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;

    if (BIAS <= 0 || BIAS >= (1 << EXP_W) - 1) begin : g_bias_chk
        $error("fp_addsub_seq: BIAS out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_wa;
    logic               r_op;
    logic [SW-1:0]      r_sig_l;
    logic [SW-1:0]      r_sig_s;
    logic               r_sub;
    logic               r_sign;
    logic [EXP_W:0]     r_exp;
    logic [SW:0]        r_sig;
    logic               r_zero;
    logic [W-1:0]       r_result;
    logic               r_busy;
    logic               r_done;
`ifdef FP_FLAGS_EN
    logic               r_ovf;
    logic               r_unf;
    logic               r_inexact;
`endif

    logic [EXP_W-1:0]   w_ea;
    logic [EXP_W-1:0]   w_eb;
    logic [EXP_W-1:0]   w_ex;
    logic [EXP_W-1:0]   w_ey;
    logic [EXP_W-1:0]   w_d;
    logic [MAN_W-1:0]   w_ma;
    logic [MAN_W-1:0]   w_mb;
    logic [MAN_W-1:0]   w_mx;
    logic [MAN_W-1:0]   w_my;
    logic               w_sa;
    logic               w_sb;
    logic               w_swap;
    logic               w_sx;
    logic               w_sub;
    logic [SW-1:0]      w_sigx;
    logic [SW-1:0]      w_sigy;
    logic [SW-1:0]      w_sigy_sh;
    logic [SW-1:0]      w_lost_mask;

    // Alignment: order by magnitude, then shift the smaller one with sticky
    always_comb begin
        w_ea        = r_wa[W-2:MAN_W];
        w_eb        = r_b[W-2:MAN_W];
        w_ma        = (w_ea == '0) ? '0 : r_wa[MAN_W-1:0];
        w_mb        = (w_eb == '0) ? '0 : r_b[MAN_W-1:0];
        w_sa        = r_wa[W-1];
        w_sb        = r_b[W-1] ^ r_op;
        w_swap      = {w_eb, w_mb} > {w_ea, w_ma};
        w_ex        = w_swap ? w_eb : w_ea;
        w_ey        = w_swap ? w_ea : w_eb;
        w_mx        = w_swap ? w_mb : w_ma;
        w_my        = w_swap ? w_ma : w_mb;
        w_sx        = w_swap ? w_sb : w_sa;
        w_sub       = w_sa ^ w_sb;
        w_sigx      = {(w_ex != '0), w_mx, 3'b000};
        w_sigy      = {(w_ey != '0), w_my, 3'b000};
        w_d         = w_ex - w_ey;
        w_lost_mask = ~({SW{1'b1}} << w_d);
        w_sigy_sh   = '0;
        if (int'(w_d) >= SW)
            w_sigy_sh = {{(SW-1){1'b0}}, |w_sigy};
        else
            w_sigy_sh = (w_sigy >> w_d)
                      | {{(SW-1){1'b0}}, |(w_sigy & w_lost_mask)};
    end

    logic [MAN_W-1:0]   w_man;
    logic               w_up;
    logic [MAN_W:0]     w_man_r;
    logic [EXP_W:0]     w_exp_r;
    logic               w_sat;
    logic               w_grs;
    logic [W-1:0]       w_rnd_res;

    // Round to nearest even on the guard/round/sticky bits
    always_comb begin
        w_man     = r_sig[SW-2:3];
        w_grs     = |r_sig[2:0];
        w_up      = r_sig[2] & (r_sig[1] | r_sig[0] | w_man[0]);
        w_man_r   = {1'b0, w_man} + {{MAN_W{1'b0}}, w_up};
        w_exp_r   = r_exp + {{EXP_W{1'b0}}, w_man_r[MAN_W]};
        w_sat     = w_exp_r[EXP_W];
        w_rnd_res = {r_sign, w_exp_r[EXP_W-1:0], w_man_r[MAN_W-1:0]};
        if (r_zero)
            w_rnd_res = '0;
        else if (w_sat)
            w_rnd_res = {r_sign, {(W-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_wa      <= '0;
            r_op      <= 1'b0;
            r_sig_l   <= '0;
            r_sig_s   <= '0;
            r_sub     <= 1'b0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_sig     <= '0;
            r_zero    <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef FP_FLAGS_EN
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inexact <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (AFin)
                r_a <= bus_in;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (GFin) begin
                        r_b     <= bus_in;
                        r_op    <= AddSubF;
                        r_wa    <= AFin ? bus_in : r_a;
                        r_busy  <= 1'b1;
                        r_state <= S_ALIGN;
`ifdef FP_FLAGS_EN
                        r_ovf     <= 1'b0;
                        r_unf     <= 1'b0;
                        r_inexact <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ALIGN: begin
                    r_sig_l <= w_sigx;
                    r_sig_s <= w_sigy_sh;
                    r_exp   <= {1'b0, w_ex};
                    r_sign  <= w_sx;
                    r_sub   <= w_sub;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_sig   <= r_sub ? {1'b0, r_sig_l} - {1'b0, r_sig_s}
                                     : {1'b0, r_sig_l} + {1'b0, r_sig_s};
                    r_zero  <= 1'b0;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_sig[SW]) begin
                        r_sig   <= {1'b0, r_sig[SW:2], r_sig[1] | r_sig[0]};
                        r_exp   <= r_exp + 1'b1;
                        r_state <= S_ROUND;
                    end else if (r_sig == '0) begin
                        r_zero  <= 1'b1;
                        r_state <= S_ROUND;
                    end else if (r_sig[SW-1]) begin
                        r_state <= S_ROUND;
                    end else if (r_exp == {{EXP_W{1'b0}}, 1'b1}) begin
                        r_result <= {r_sign, {(W-1){1'b0}}};
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
`ifdef FP_FLAGS_EN
                        r_unf     <= 1'b1;
                        r_inexact <= w_grs;
`endif
                    end else begin
                        // Move to ROUND as soon as the shift lands the hidden bit
                        r_sig   <= r_sig << 1;
                        r_exp   <= r_exp - 1'b1;
                        if (r_sig[SW-2])
                            r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_result <= w_rnd_res;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
`ifdef FP_FLAGS_EN
                    r_ovf     <= ~r_zero & w_sat;
                    r_inexact <= ~r_zero & w_grs;
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result  = r_result;
    assign bus_out = GFout ? r_result : '0;
    assign busy    = r_busy;
    assign done    = r_done;
`ifdef FP_FLAGS_EN
    assign ovf     = r_ovf;
    assign unf     = r_unf;
    assign inexact = r_inexact;
`endif

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: results, latency, flags, reset abort.
`timescale 1ns/1ps
module tb_fp_addsub_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] bus_in;
    logic       AFin;
    logic       GFin;
    logic       AddSubF;
    logic       GFout;
    logic [8:0] bus_out;
    logic [8:0] result;
    logic       busy;
    logic       done;
`ifdef FP_FLAGS_EN
    logic       ovf;
    logic       unf;
    logic       inexact;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_addsub_seq dut (
        .clk     (clk),
        .rst     (rst),
        .bus_in  (bus_in),
        .AFin    (AFin),
        .GFin    (GFin),
        .AddSubF (AddSubF),
        .GFout   (GFout),
        .bus_out (bus_out),
        .result  (result),
        .busy    (busy),
        .done    (done)
`ifdef FP_FLAGS_EN
        ,
        .ovf     (ovf),
        .unf     (unf),
        .inexact (inexact)
`endif
    );

    // Loads A, then B with GFin; returns edges from the GFin edge to done (-1 on timeout)
    task automatic run_op(input logic [8:0] a, input logic [8:0] b,
                          input logic op, output int lat);
        @(posedge clk); #1;
        bus_in = a; AFin = 1'b1;
        @(posedge clk); #1;
        AFin = 1'b0; bus_in = b; GFin = 1'b1; AddSubF = op;
        @(posedge clk); #1;
        GFin = 1'b0; AddSubF = 1'b0; bus_in = '0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        GFout = 1'b1; #1;
        total++; if (result !== 9'h000) begin bad++; $display("FAIL reset_result got=%h want=000", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (bus_out !== 9'h000) begin bad++; $display("FAIL reset_bus_out got=%h want=000", bus_out); end
`ifdef FP_FLAGS_EN
        total++; if ({ovf, unf, inexact} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {ovf, unf, inexact}); end
`endif
        GFout = 1'b0;
    endtask

    task automatic test_vec(input string nm, input logic [8:0] a, input logic [8:0] b,
                            input logic op, input logic [8:0] exp_res, input int exp_lat,
                            input logic [2:0] exp_flags);
        int lat;
        run_op(a, b, op, lat);
        total++; if (result !== exp_res) begin bad++; $display("FAIL %s_result got=%h want=%h", nm, result, exp_res); end
        if (exp_lat > 0) begin
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, exp_lat); end
        end else begin
            total++; if (lat < 0) begin bad++; $display("FAIL %s_timeout got=%0d want=done", nm, lat); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done got=%b want=0", nm, busy); end
`ifdef FP_FLAGS_EN
        total++; if ({ovf, unf, inexact} !== exp_flags) begin bad++; $display("FAIL %s_flags got=%b want=%b", nm, {ovf, unf, inexact}, exp_flags); end
`else
        if (exp_flags === 3'bxxx) $display("flags unused");
`endif
    endtask

    task automatic test_saturate();
        test_vec("saturate", 9'h0FF, 9'h0FF, 1'b0, 9'h0FF, 4, 3'b100);
        GFout = 1'b1; #1;
        total++; if (bus_out !== 9'h0FF) begin bad++; $display("FAIL sat_bus_out_on got=%h want=0ff", bus_out); end
        GFout = 1'b0; #1;
        total++; if (bus_out !== 9'h000) begin bad++; $display("FAIL sat_bus_out_off got=%h want=000", bus_out); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus_in = 9'h071; AFin = 1'b1;
        @(posedge clk); #1;
        AFin = 1'b0; bus_in = 9'h070; GFin = 1'b1; AddSubF = 1'b1;
        @(posedge clk); #1;
        GFin = 1'b0; AddSubF = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
        rst = 1'b1; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
        total++; if (result !== 9'h000) begin bad++; $display("FAIL rstmid_result got=%h want=000", result); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_busy_gfin();
        int lat;
        @(posedge clk); #1;
        bus_in = 9'h071; AFin = 1'b1;
        @(posedge clk); #1;
        AFin = 1'b0; bus_in = 9'h070; GFin = 1'b1; AddSubF = 1'b1;
        @(posedge clk); #1;
        GFin = 1'b0; AddSubF = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            // Stray start plus an A reload while the op is in flight
            if (i == 2) begin bus_in = 9'h1AA; GFin = 1'b1; AFin = 1'b1; end
            if (i == 3) begin bus_in = 9'h000; GFin = 1'b0; AFin = 1'b0; end
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        total++; if (result !== 9'h030) begin bad++; $display("FAIL busygf_result got=%h want=030", result); end
        total++; if (lat !== 7) begin bad++; $display("FAIL busygf_latency got=%0d want=7", lat); end
        // A keeps the mid-op reload; B=+0 so the result is A itself
        @(posedge clk); #1;
        bus_in = 9'h000; GFin = 1'b1;
        @(posedge clk); #1;
        GFin = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        total++; if (result !== 9'h1AA) begin bad++; $display("FAIL areload_result got=%h want=1aa", result); end
        total++; if (lat !== 4) begin bad++; $display("FAIL areload_latency got=%0d want=4", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(9'h070, 9'h070, 1'b0, lat);
        total++; if (result !== 9'h080) begin bad++; $display("FAIL b2b_first got=%h want=080", result); end
        // GFin sampled while the unit sits in DONE
        bus_in = 9'h070; GFin = 1'b1; AddSubF = 1'b1;
        @(posedge clk); #1;
        GFin = 1'b0; AddSubF = 1'b0; bus_in = '0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b want=1", busy); end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        total++; if (result !== 9'h000) begin bad++; $display("FAIL b2b_second got=%h want=000", result); end
        total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency got=%0d want=4", lat); end
    endtask

    initial begin
        rst = 1'b1; bus_in = '0; AFin = 1'b0; GFin = 1'b0;
        AddSubF = 1'b0; GFout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_vec("add_carry",  9'h070, 9'h070, 1'b0, 9'h080, 4, 3'b000);
        test_vec("sub_norm",   9'h071, 9'h070, 1'b1, 9'h030, 7, 3'b000);
        test_vec("cancel",     9'h070, 9'h070, 1'b1, 9'h000, 4, 3'b000);
        test_vec("tie_even",   9'h070, 9'h020, 1'b0, 9'h070, 4, 3'b001);
        test_vec("round_up",   9'h07F, 9'h050, 1'b0, 9'h082, 4, 3'b001);
        test_vec("mixed_sign", 9'h070, 9'h180, 1'b0, 9'h170, 4, 3'b000);
        test_vec("sticky_far", 9'h0F0, 9'h010, 1'b1, 9'h0F0, 4, 3'b001);
        test_vec("flush",      9'h010, 9'h011, 1'b1, 9'h100, 0, 3'b010);
        test_saturate();
        test_reset_mid();
        test_busy_gfin();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
